// File: rtl/switch_seq_capture_if.sv
// rtl/switch_seq_capture_if.sv - switch front-end signal bundle
// master drives raw switches and clear; slave returns debounced state, edge events and the captured code.
interface switch_seq_capture_if #(
  parameter int NUM_SW    = 10,
  parameter int IDX_W     = 4,
  parameter int SEQ_DEPTH = 4,
  parameter int CNT_W     = 3
);
  logic [NUM_SW-1:0]          sw;
  logic                       clear;
  logic [NUM_SW-1:0]          sw_stable;
  logic                       change_valid;
  logic                       change_dir;
  logic [IDX_W-1:0]           change_idx;
  logic [IDX_W-1:0]           up_count;
  logic                       conflict;
  logic [SEQ_DEPTH*IDX_W-1:0] seq_digits;
  logic [CNT_W-1:0]           seq_count;
  logic                       seq_full;

  modport master (
    output sw, clear,
    input  sw_stable, change_valid, change_dir, change_idx, up_count, conflict,
           seq_digits, seq_count, seq_full
  );

  modport slave (
    input  sw, clear,
    output sw_stable, change_valid, change_dir, change_idx, up_count, conflict,
           seq_digits, seq_count, seq_full
  );
endinterface

// File: rtl/switch_seq_capture.sv
// rtl/switch_seq_capture.sv - parallel switch debounce, edge report and press-sequence capture
// Every switch is synchronised and debounced independently; single-switch presses from idle become code digits.
module switch_seq_capture #(
  parameter int NUM_SW    = 10,
  parameter int IDX_W     = 4,
  parameter int SEQ_DEPTH = 4,
  parameter int DEB_CNT   = 4,
  parameter int CNT_W     = 3
) (
  input logic            clk,
  input logic            rst,
  switch_seq_capture_if.slave bus
);
  localparam int DCW = $clog2(DEB_CNT + 1);

  logic [NUM_SW-1:0] sync1, sync2, stable, prev;
  logic [DCW-1:0]    deb_cnt [NUM_SW];

  logic [NUM_SW-1:0] chg;
  logic [IDX_W-1:0]  lo_idx, pc_new, pc_prev;
  logic              lo_dir, any_chg, capture;

  logic                       change_valid, change_dir, conflict, seq_full;
  logic [IDX_W-1:0]           change_idx, up_count;
  logic [SEQ_DEPTH*IDX_W-1:0] seq_digits;
  logic [CNT_W-1:0]           seq_count;

  function automatic logic [IDX_W-1:0] popcount(input logic [NUM_SW-1:0] v);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SW; i++) n = n + IDX_W'(v[i]);
    return n;
  endfunction

  // Scanning downward leaves the lowest changed index as the reported one.
  always_comb begin
    chg    = stable ^ prev;
    lo_idx = '0;
    lo_dir = 1'b0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (chg[i]) begin
        lo_idx = IDX_W'(i);
        lo_dir = stable[i];
      end
    end
    any_chg = |chg;
    pc_new  = popcount(stable);
    pc_prev = popcount(prev);
    capture = any_chg && (pc_prev == '0) && (pc_new == IDX_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      prev   <= '0;
      for (int i = 0; i < NUM_SW; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= bus.sw;
      sync2 <= sync1;
      prev  <= stable;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CNT - 1)) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change_valid <= 1'b0;
      change_dir   <= 1'b0;
      change_idx   <= '1;
      up_count     <= '0;
      conflict     <= 1'b0;
      seq_digits   <= '1;
      seq_count    <= '0;
      seq_full     <= 1'b0;
    end else begin
      change_valid <= any_chg;
      if (any_chg) begin
        change_dir <= lo_dir;
        change_idx <= lo_idx;
      end
      up_count <= pc_new;
      conflict <= (pc_new > IDX_W'(1));
      // Clear takes priority over a capture landing in the same cycle.
      if (bus.clear) begin
        seq_digits <= '1;
        seq_count  <= '0;
        seq_full   <= 1'b0;
      end else if (capture && !seq_full) begin
        for (int k = 0; k < SEQ_DEPTH; k++) begin
          if (seq_count == CNT_W'(k)) seq_digits[k*IDX_W +: IDX_W] <= lo_idx;
        end
        seq_count <= seq_count + CNT_W'(1);
        seq_full  <= (seq_count == CNT_W'(SEQ_DEPTH - 1));
      end
    end
  end

  assign bus.sw_stable    = stable;
  assign bus.change_valid = change_valid;
  assign bus.change_dir   = change_dir;
  assign bus.change_idx   = change_idx;
  assign bus.up_count     = up_count;
  assign bus.conflict     = conflict;
  assign bus.seq_digits   = seq_digits;
  assign bus.seq_count    = seq_count;
  assign bus.seq_full     = seq_full;
endmodule
